// File: rtl/spi_command_router.sv
// Host command router: decodes the SPI command byte, assembles write records and
// commits each one atomically to the selected channel FIFO; answers status reads.
module spi_command_router #(
  parameter int unsigned WordSize    = 8,
  parameter int unsigned RecordWords = 8,
  parameter int unsigned Channels    = 2,
  parameter int unsigned ChW         = (Channels > 1) ? $clog2(Channels) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cs,
  input  logic                            word_ready,
  input  logic [WordSize-1:0]             rx_word,
  output logic [WordSize-1:0]             tx_word,
  input  logic [Channels*8-1:0]           free_slots,
  output logic                            rec_valid,
  output logic [ChW-1:0]                  rec_channel,
  output logic [RecordWords*WordSize-1:0] rec_data,
  output logic [2:0]                      status_flags
);

  localparam int unsigned CntW = (RecordWords > 1) ? $clog2(RecordWords) : 1;
  localparam int unsigned IdxW = $clog2(Channels + 2);
  localparam logic [IdxW-1:0] IdxMax  = IdxW'(Channels + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(RecordWords - 1);
  localparam logic [3:0] OpStatus = 4'h0;
  localparam logic [3:0] OpWrite  = 4'h1;
  localparam logic [3:0] OpClear  = 4'h2;

  typedef enum logic [1:0] {IDLE, STATUS, WRITE, DISCARD} state_e;

  state_e state_q, state_d;
  logic [CntW-1:0]                      cnt_q, cnt_d;
  logic [RecordWords-1:0][WordSize-1:0] buf_q, buf_d;
  logic [ChW-1:0]                       ch_q, ch_d;
  logic [IdxW-1:0]                      idx_q, idx_d, idx_n;
  logic [WordSize-1:0]                  tx_q, tx_d;
  logic                                 recv_q, recv_d;
  logic [ChW-1:0]                       rech_q, rech_d;
  logic [RecordWords*WordSize-1:0]      recd_q, recd_d;
  logic [2:0]                           flags_q, flags_d, flag_set;
  logic                                 flag_clr;
  logic                                 cs_q;
  logic [7:0]                           fs0, fs_ch;
  logic                                 ch_ok;

  assign fs0   = free_slots[7:0];
  assign fs_ch = free_slots[32'(ch_q)*8 +: 8];
  assign ch_ok = 32'(rx_word[3:0]) < Channels;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cs) begin
      state_d = IDLE;
    end else if (word_ready && state_q == IDLE) begin
      case (rx_word[7:4])
        OpStatus: state_d = STATUS;
        OpWrite:  state_d = ch_ok ? WRITE : DISCARD;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    ch_d     = ch_q;
    idx_d    = idx_q;
    idx_n    = (idx_q == IdxMax) ? idx_q : idx_q + IdxW'(1);
    tx_d     = tx_q;
    recv_d   = 1'b0;
    rech_d   = rech_q;
    recd_d   = recd_q;
    flag_set = '0;
    flag_clr = 1'b0;
    if (cs) begin
      idx_d = '0;
      cnt_d = '0;
      if (state_q == WRITE && cnt_q != '0) flag_set[1] = 1'b1;
      if (!cs_q) tx_d = WordSize'(fs0);
    end else if (word_ready) begin
      case (state_q)
        IDLE: begin
          tx_d  = WordSize'(fs0);
          cnt_d = '0;
          case (rx_word[7:4])
            OpStatus: idx_d = '0;
            OpWrite: begin
              tx_d = '0;
              if (ch_ok) ch_d = rx_word[ChW-1:0];
              else       flag_set[0] = 1'b1;
            end
            OpClear: flag_clr = 1'b1;
            default: ;
          endcase
        end
        STATUS: begin
          // idx names the response now being loaded for the following byte
          idx_d = idx_n;
          if (32'(idx_n) < Channels)       tx_d = WordSize'(free_slots[32'(idx_n)*8 +: 8]);
          else if (32'(idx_n) == Channels) tx_d = WordSize'({flags_q, 5'b0});
          else                             tx_d = '0;
        end
        WRITE: begin
          tx_d         = '0;
          buf_d[cnt_q] = rx_word;
          if (cnt_q == CntLast) begin
            cnt_d = '0;
            if (fs_ch != 8'd0) begin
              recv_d = 1'b1;
              rech_d = ch_q;
              recd_d = buf_d;
            end else begin
              flag_set[2] = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: tx_d = '0;
      endcase
    end
    flags_d = (flag_clr ? 3'b000 : flags_q) | flag_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      buf_q   <= '0;
      ch_q    <= '0;
      idx_q   <= '0;
      tx_q    <= '0;
      recv_q  <= 1'b0;
      rech_q  <= '0;
      recd_q  <= '0;
      flags_q <= '0;
      cs_q    <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      ch_q    <= ch_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      recv_q  <= recv_d;
      rech_q  <= rech_d;
      recd_q  <= recd_d;
      flags_q <= flags_d;
      cs_q    <= cs;
    end
  end

  assign tx_word      = tx_q;
  assign rec_valid    = recv_q;
  assign rec_channel  = rech_q;
  assign rec_data     = recd_q;
  assign status_flags = flags_q;

endmodule

// File: tb/tb_spi_command_router.sv
// Directed bench for spi_command_router (RecordWords=4, Channels=2); committed
// records are checked against a queue of expected {channel, data} entries.
module tb_spi_command_router;

  localparam int unsigned RW = 4;
  localparam int unsigned CH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cs = 1'b1;
  logic          word_ready = 1'b0;
  logic [7:0]    rx_word = '0;
  logic [7:0]    tx_word;
  logic [15:0]   free_slots = {8'd5, 8'd5};
  logic          rec_valid;
  logic          rec_channel;
  logic [31:0]   rec_data;
  logic [2:0]    status_flags;

  int n_pass = 0;
  int n_total = 0;
  logic [32:0] exp_q[$];

  spi_command_router #(.WordSize(8), .RecordWords(RW), .Channels(CH)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .word_ready(word_ready), .rx_word(rx_word),
    .tx_word(tx_word), .free_slots(free_slots), .rec_valid(rec_valid),
    .rec_channel(rec_channel), .rec_data(rec_data), .status_flags(status_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_word = b;
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_start();
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic frame_end();
    @(negedge clk);
    cs = 1'b1;
    idle(3);
  endtask

  task automatic write_record(input logic [31:0] d, input logic ch, input logic commit);
    for (int i = 0; i < 4; i++) begin
      if (i == 3 && commit) exp_q.push_back({ch, d});
      send(d[8*i +: 8]);
    end
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n && rec_valid) begin
      if (exp_q.size() == 0) begin
        chk("rec_valid_unexpected", 64'(rec_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rec_channel", 64'(rec_channel), 64'(e[32]));
        chk("rec_data", 64'(rec_data), 64'(e[31:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle(3);
    chk("rst_tx", 64'(tx_word), 64'd0);
    chk("rst_rec_valid", 64'(rec_valid), 64'd0);
    chk("rst_rec_channel", 64'(rec_channel), 64'd0);
    chk("rst_rec_data", 64'(rec_data), 64'd0);
    chk("rst_flags", 64'(status_flags), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // reset mid-write, then a clean frame
    frame_start();
    send(8'h10);
    send(8'h11);
    send(8'h22);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx", 64'(tx_word), 64'd0);
    chk("midrst_rec_valid", 64'(rec_valid), 64'd0);
    chk("midrst_rec_data", 64'(rec_data), 64'd0);
    chk("midrst_flags", 64'(status_flags), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cs = 1'b1;
    idle(2);
    frame_start();
    send(8'h10);
    write_record(32'h04030201, 1'b0, 1'b1);
    idle(2);
    chk("after_rst_commit", 64'(exp_q.size()), 64'd0);
    frame_end();
    chk("cs_rise_tx", 64'(tx_word), 64'd5);

    // two back-to-back records on channel 1
    frame_start();
    send(8'h11);
    chk("write_tx0", 64'(tx_word), 64'd0);
    write_record(32'hA3A2A1A0, 1'b1, 1'b1);
    write_record(32'hA7A6A5A4, 1'b1, 1'b1);
    chk("write_tx1", 64'(tx_word), 64'd0);
    idle(2);
    chk("stream_done", 64'(exp_q.size()), 64'd0);
    chk("stream_flags", 64'(status_flags), 64'd0);
    frame_end();

    // overflow on full channel 0
    free_slots = {8'd5, 8'd0};
    frame_start();
    send(8'h10);
    write_record(32'h0D0C0B0A, 1'b0, 1'b0);
    frame_end();
    chk("overflow_flags", 64'(status_flags), 64'h4);

    // status readback
    free_slots = {8'd3, 8'd16};
    frame_start();
    send(8'h00);
    chk("status_r0", 64'(tx_word), 64'd16);
    send(8'hFF);
    chk("status_r1", 64'(tx_word), 64'd3);
    send(8'hFF);
    chk("status_flags_byte", 64'(tx_word), 64'h80);
    send(8'hFF);
    chk("status_pad0", 64'(tx_word), 64'h00);
    send(8'hFF);
    chk("status_pad1", 64'(tx_word), 64'h00);
    frame_end();
    chk("status_cs_rise_tx", 64'(tx_word), 64'd16);

    // clear
    frame_start();
    send(8'h20);
    frame_end();
    chk("clear_flags", 64'(status_flags), 64'd0);

    // truncated frame then clean frame
    free_slots = {8'd5, 8'd5};
    frame_start();
    send(8'h10);
    send(8'h31);
    send(8'h32);
    send(8'h33);
    frame_end();
    chk("frame_err_flags", 64'(status_flags), 64'h2);
    frame_start();
    send(8'h10);
    write_record(32'h44434241, 1'b0, 1'b1);
    idle(2);
    chk("post_frame_err_commit", 64'(exp_q.size()), 64'd0);
    frame_end();
    chk("frame_err_sticky", 64'(status_flags), 64'h2);
    frame_start();
    send(8'h20);
    frame_end();

    // bad channel and unknown opcode
    frame_start();
    send(8'h13);
    chk("discard_tx", 64'(tx_word), 64'd0);
    write_record(32'h57565554, 1'b1, 1'b0);
    write_record(32'h5B5A5958, 1'b1, 1'b0);
    chk("discard_tx_end", 64'(tx_word), 64'd0);
    frame_end();
    chk("bad_channel_flags", 64'(status_flags), 64'h1);
    free_slots = {8'd5, 8'h77};
    frame_start();
    send(8'h50);
    chk("noop_tx0", 64'(tx_word), 64'h77);
    free_slots = {8'd5, 8'h33};
    send(8'h50);
    chk("noop_tx1", 64'(tx_word), 64'h33);
    send(8'h10);
    write_record(32'h6C6B6A69, 1'b0, 1'b1);
    idle(2);
    chk("noop_then_write", 64'(exp_q.size()), 64'd0);
    frame_end();

    idle(5);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_command_router.md
Name: spi_command_router

Overview:
Multi-channel successor to the single-FIFO host command FSM. It sits between spi_secondary and N motion-segment FIFOs. It decodes the host command byte and assembles incoming bytes into whole records. Each record is committed atomically to the selected channel's FIFO, so a partial record never reaches a FIFO. It returns per-channel free-slot counts and sticky error flags to the host.

Parameters:
WordSize, 8, SPI word width in bits
RecordWords, 8, words per record (record = RecordWords*WordSize bits)
Channels, 2, number of downstream FIFOs (1..15)
ChW, $clog2(Channels) min 1, width of channel index

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cs  in  1  SPI chip select, high = deselected
word_ready  in  1  one-cycle strobe: rx_word valid
rx_word  in  WordSize  byte received from host
tx_word  out  WordSize  byte to load into spi_secondary for the next transfer
free_slots  in  Channels*8  packed free-record counts, channel c at [8c+7:8c]
rec_valid  out  1  one-cycle commit strobe
rec_channel  out  ChW  target channel of rec_data
rec_data  out  RecordWords*WordSize  assembled record, first byte in bits [WordSize-1:0]
status_flags  out  3  {overflow, frame_err, bad_channel}, sticky

Behaviour:
- Reset (rst_n low, async): state=IDLE, byte counter=0, record buffer=0, tx_word=0, rec_valid=0, rec_channel=0, rec_data=0, flags=0.
- Command byte: opcode = rx_word[7:4], channel = rx_word[3:0]. 0x0 STATUS, 0x1 WRITE, 0x2 CLEAR. Any other opcode is a no-op; the FSM stays in IDLE.
- Bytes are acted on only on cycles with word_ready=1 and cs=0.
- States: IDLE, STATUS, WRITE, DISCARD.
- IDLE transitions:
  - STATUS -> STATUS, status index=0.
  - WRITE with channel<Channels -> WRITE, latch channel.
  - WRITE with channel>=Channels -> DISCARD, set bad_channel.
  - CLEAR -> clear all three flags on the same edge, stay IDLE.
- IDLE tx_word = free_slots of channel 0 (compatible with single-FIFO hosts).
- tx_word is registered. On the edge that accepts a byte, it is loaded with the response for the next byte.
- STATUS response sequence: free_slots[0], free_slots[1] ... free_slots[Channels-1], then {flags,5'b0}, then 0x00 for all further bytes. The index saturates.
- WRITE:
  - Each byte is written into buffer slot byte_cnt. byte_cnt increments and wraps at RecordWords.
  - On the byte where byte_cnt==RecordWords-1 with free_slots[ch]!=0: next cycle rec_valid=1 for exactly one cycle, with rec_data = full record and rec_channel = ch.
  - On that byte with free_slots[ch]==0: record dropped, overflow set, no strobe.
  - Records stream back-to-back until cs rises. tx_word=0x00 throughout WRITE.
- DISCARD: all bytes ignored, tx_word=0x00.
- cs high, any cycle and highest priority: state -> IDLE, status index=0.
  - If in WRITE with byte_cnt!=0: set frame_err, discard the partial record, byte_cnt=0.
  - A rec_valid already scheduled for this cycle still fires.
- Downstream contract: a FIFO updates its free_slots within 2 clk of rec_valid. A record spans ≥8 SPI clocks per byte, so no credit tracking is needed internally.
- Flags are cleared only by rst_n or the CLEAR command. Clear and set on the same edge: set wins.
- tx_word is only updated when a byte is accepted or cs rises; cs rising reloads it with the IDLE value.

Test Plan:
All scenarios use RecordWords=4, Channels=2.
- Reset mid-WRITE after 2 bytes -> all outputs 0, flags 0; next cs frame behaves from IDLE.
- cs low, 0x11, then bytes 0xA0..0xA7 with free_slots={8'd5,8'd5} -> two rec_valid pulses on channel 1, rec_data 0xA3A2A1A0 then 0xA7A6A5A4; flags 000.
- cs low, 0x00, then 4 dummy bytes with free_slots ch0=16, ch1=3 and overflow flag set -> tx_word sequence 16, 3, 0x80, 0x00.
- WRITE ch0 with free_slots ch0=0, 4 bytes -> no rec_valid, overflow=1; then CLEAR frame (0x20) -> flags 000.
- WRITE ch0, 3 bytes, then cs high -> no rec_valid, frame_err=1, byte_cnt=0; next frame 0x10 + 4 bytes commits cleanly.
- Command 0x13 (channel 3 ≥ Channels) + 8 bytes -> no rec_valid, bad_channel=1; command 0x50 -> FSM stays IDLE and tx_word tracks free_slots[0].
